// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// Module   : multicycle_ctrl_pkg
// Brief    : Shared constants, opcodes, state and select encodings for the
//            RV32I multi-cycle sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package multicycle_ctrl_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Sequencer states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_DECODE = 3'd2;
  localparam state_t ST_EXEC   = 3'd3;
  localparam state_t ST_MEM    = 3'd4;
  localparam state_t ST_WB     = 3'd5;
  localparam state_t ST_TRAP   = 3'd6;

  // Bit positions of the one-hot instruction class vector
  localparam int CLS_OP       = 0;
  localparam int CLS_OP_IMM   = 1;
  localparam int CLS_LUI      = 2;
  localparam int CLS_AUIPC    = 3;
  localparam int CLS_JAL      = 4;
  localparam int CLS_JALR     = 5;
  localparam int CLS_LOAD     = 6;
  localparam int CLS_STORE    = 7;
  localparam int CLS_BRANCH   = 8;
  localparam int CLS_MISC_MEM = 9;
  localparam int CLS_SYSTEM   = 10;
  localparam int NUM_CLS      = 11;

  localparam logic [1:0] PC_SEL_PC4 = 2'd0;
  localparam logic [1:0] PC_SEL_IMM = 2'd1;
  localparam logic [1:0] PC_SEL_ALU = 2'd2;

  localparam logic [1:0] ALU_A_RS1  = 2'd0;
  localparam logic [1:0] ALU_A_PC   = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_inst_class_dec.sv
// ============================================================================
// Module   : inst_class_dec
// Brief    : Opcode to one-hot instruction class plus a supported flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_class_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0]         opcode,
  output logic [NUM_CLS-1:0] cls,
  output logic               valid
);

  always_comb begin
    cls = '0;
    case (opcode)
      OPC_OP:       cls[CLS_OP]       = 1'b1;
      OPC_OP_IMM:   cls[CLS_OP_IMM]   = 1'b1;
      OPC_LUI:      cls[CLS_LUI]      = 1'b1;
      OPC_AUIPC:    cls[CLS_AUIPC]    = 1'b1;
      OPC_JAL:      cls[CLS_JAL]      = 1'b1;
      OPC_JALR:     cls[CLS_JALR]     = 1'b1;
      OPC_LOAD:     cls[CLS_LOAD]     = 1'b1;
      OPC_STORE:    cls[CLS_STORE]    = 1'b1;
      OPC_BRANCH:   cls[CLS_BRANCH]   = 1'b1;
      OPC_MISC_MEM: cls[CLS_MISC_MEM] = 1'b1;
      OPC_SYSTEM:   cls[CLS_SYSTEM]   = 1'b1;
      default:      cls               = '0;
    endcase
    valid = |cls;
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : RV32I multi-cycle sequencer driving datapath selects/enables and
//            counting retired instructions.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] inst,
  input  logic                  mem_ready,
  input  logic                  br_taken,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  addr_sel,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic [1:0]            pc_sel,
  output logic [1:0]            alu_a_sel,
  output logic                  alu_b_sel,
  output logic                  reg_we,
  output logic [1:0]            wb_sel,
  output logic                  retire,
  output logic [31:0]           instret,
  output logic                  illegal
);

  state_t               state_q, state_d;
  logic [31:0]          instret_q, instret_d;
  logic [NUM_CLS-1:0]   cls;
  logic                 cls_valid;
  logic [1:0]           ex_a_sel;
  logic                 ex_b_sel;
  logic                 unused_inst_hi;

  assign unused_inst_hi = ^inst[DATA_WIDTH-1:7];

  inst_class_dec u_class_dec (
    .opcode (inst[6:0]),
    .cls    (cls),
    .valid  (cls_valid)
  );

  // ALU operand selects per class; reused unchanged in MEM and WB
  always_comb begin
    ex_a_sel = ALU_A_RS1;
    ex_b_sel = 1'b0;
    if (cls[CLS_AUIPC]) ex_a_sel = ALU_A_PC;
    if (cls[CLS_LUI])   ex_a_sel = ALU_A_ZERO;
    if (cls[CLS_OP_IMM] | cls[CLS_LOAD] | cls[CLS_STORE] | cls[CLS_JALR] |
        cls[CLS_AUIPC]  | cls[CLS_LUI])
      ex_b_sel = 1'b1;
  end

  // mem_req/addr_sel depend on state_q only, so they cannot glitch on mem_ready
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_SEL_PC4;
    alu_a_sel = ALU_A_RS1;
    alu_b_sel = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = WB_SEL_ALU;
    retire    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = cls_valid ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        alu_a_sel = ex_a_sel;
        alu_b_sel = ex_b_sel;
        if (cls[CLS_LOAD] | cls[CLS_STORE]) begin
          state_d = ST_MEM;
        end else if (cls[CLS_BRANCH]) begin
          pc_we   = 1'b1;
          retire  = 1'b1;
          pc_sel  = br_taken ? PC_SEL_IMM : PC_SEL_PC4;
          state_d = ST_FETCH;
        end else if (cls[CLS_MISC_MEM] | cls[CLS_SYSTEM]) begin
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        alu_a_sel = ALU_A_RS1;
        alu_b_sel = 1'b1;
        mem_we    = cls[CLS_STORE];
        if (mem_ready) begin
          if (cls[CLS_STORE]) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        retire    = 1'b1;
        alu_a_sel = ex_a_sel;
        alu_b_sel = ex_b_sel;
        if (cls[CLS_LOAD])
          wb_sel = WB_SEL_MEM;
        else if (cls[CLS_JAL] | cls[CLS_JALR])
          wb_sel = WB_SEL_PC4;
        if (cls[CLS_JAL])
          pc_sel = PC_SEL_IMM;
        else if (cls[CLS_JALR])
          pc_sel = PC_SEL_ALU;
        state_d = ST_FETCH;
      end
      ST_TRAP: illegal = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  assign instret_d = instret_q + {31'd0, retire};
  assign instret   = instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Self-checking bench for multicycle_ctrl (directed + random).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  localparam logic [6:0] OP = 7'b0110011, OP_IMM = 7'b0010011, LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011, BRANCH = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] MISC = 7'b0001111, SYS = 7'b1110011;

  // Packed view: {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_a, alu_b, reg_we, wb_sel, retire, illegal}
  localparam logic [14:0] O_MREQ = 15'h4000, O_MWE = 15'h2000, O_ASEL = 15'h1000;
  localparam logic [14:0] O_IRWE = 15'h0800, O_PCWE = 15'h0400, O_REGWE = 15'h0010;
  localparam logic [14:0] O_RET = 15'h0002, O_ILL = 15'h0001;

  typedef struct packed {
    logic        mr;
    logic        br;
    logic [31:0] iw;
    logic [14:0] o;
  } rec_t;

  logic        clk, rst, mem_ready, br_taken;
  logic [31:0] inst;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, alu_b_sel, reg_we, retire, illegal;
  logic [1:0]  pc_sel, alu_a_sel, wb_sel;
  logic [31:0] instret;
  logic [14:0] obs;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret;
  rec_t        exp_q[$];

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready), .br_taken(br_taken),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .reg_we(reg_we), .wb_sel(wb_sel), .retire(retire), .instret(instret), .illegal(illegal)
  );

  assign obs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
                reg_we, wb_sel, retire, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] sel(input logic [1:0] pcs, input logic [1:0] a,
                                      input logic b, input logic [1:0] wb);
    return {5'b0, pcs, a, b, 1'b0, wb, 2'b0};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input logic mr, input logic br);
    @(negedge clk);
    mem_ready = mr;
    br_taken  = br;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0; br_taken = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic push(input logic mr, input logic br, input logic [31:0] iw, input logic [14:0] o);
    rec_t r;
    r.mr = mr; r.br = br; r.iw = iw; r.o = o;
    exp_q.push_back(r);
  endtask

  // Builds the expected per-cycle output trace of one instruction from the
  // sequencing rules: fetch waits, decode, execute, optional memory, write-back.
  task automatic model_inst(input logic [31:0] iw, input int fw, input int mw, input logic br);
    logic [6:0] opc;
    logic [1:0] a, pcs, wb;
    logic       b, st;
    opc = iw[6:0];
    a   = 2'd0;
    b   = (opc inside {OP_IMM, LOAD, STORE, JALR, AUIPC, LUI});
    if (opc == AUIPC) a = 2'd1;
    if (opc == LUI)   a = 2'd2;
    st  = (opc == STORE);
    pcs = (opc == JAL) ? 2'd1 : (opc == JALR) ? 2'd2 : 2'd0;
    wb  = (opc == LOAD) ? 2'd1 : (opc inside {JAL, JALR}) ? 2'd2 : 2'd0;
    for (int i = 0; i < fw; i++) push(1'b0, rbit(), iw, O_MREQ);
    push(1'b1, rbit(), iw, O_MREQ | O_IRWE);
    push(rbit(), rbit(), iw, 15'h0);
    if (opc == BRANCH) begin
      push(rbit(), br, iw, O_PCWE | O_RET | sel({1'b0, br}, 2'd0, 1'b0, 2'd0));
    end else if (opc inside {MISC, SYS}) begin
      push(rbit(), rbit(), iw, O_PCWE | O_RET);
    end else begin
      push(rbit(), rbit(), iw, sel(2'd0, a, b, 2'd0));
      if (opc inside {LOAD, STORE}) begin
        for (int i = 0; i < mw; i++)
          push(1'b0, rbit(), iw, O_MREQ | O_ASEL | (st ? O_MWE : 15'h0) | sel(2'd0, 2'd0, 1'b1, 2'd0));
        push(1'b1, rbit(), iw, O_MREQ | O_ASEL | (st ? (O_MWE | O_PCWE | O_RET) : 15'h0)
                               | sel(2'd0, 2'd0, 1'b1, 2'd0));
      end
      if (!st) push(rbit(), rbit(), iw, O_PCWE | O_REGWE | O_RET | sel(pcs, a, b, wb));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; inst = 32'h0; mem_ready = 1'b1; br_taken = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (obs !== 15'h0) begin errors++; $display("FAIL reset_outputs: got %h expected %h", obs, 15'h0); end
    checks++; if (instret !== 32'h0) begin errors++; $display("FAIL reset_instret: got %h expected 0", instret); end
    @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
    checks++; if (obs !== 15'h0) begin errors++; $display("FAIL idle_outputs: got %h expected 0", obs); end
    cyc(1'b0, 1'b0);
    checks++; if (obs !== O_MREQ) begin errors++; $display("FAIL idle_to_fetch: got %h expected %h", obs, O_MREQ); end
    cyc(1'b0, 1'b0);
    checks++; if (obs !== O_MREQ) begin errors++; $display("FAIL fetch_hold: got %h expected %h", obs, O_MREQ); end
  endtask

  task automatic test_addi();
    do_reset(); inst = 32'h00500093;
    cyc(1'b1, 1'b0);
    checks++; if (obs !== (O_MREQ | O_IRWE)) begin errors++; $display("FAIL addi_fetch: got %h expected %h", obs, O_MREQ | O_IRWE); end
    cyc(1'b1, 1'b1);
    checks++; if (obs !== 15'h0) begin errors++; $display("FAIL addi_decode: got %h expected 0", obs); end
    cyc(1'b1, 1'b1);
    checks++; if (obs !== sel(2'd0, 2'd0, 1'b1, 2'd0)) begin errors++; $display("FAIL addi_exec: got %h expected %h", obs, sel(2'd0, 2'd0, 1'b1, 2'd0)); end
    cyc(1'b1, 1'b1);
    checks++; if (obs !== (O_PCWE | O_REGWE | O_RET | sel(2'd0, 2'd0, 1'b1, 2'd0))) begin
      errors++; $display("FAIL addi_wb: got %h expected %h", obs, O_PCWE | O_REGWE | O_RET | sel(2'd0, 2'd0, 1'b1, 2'd0)); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL addi_instret_before: got %0d expected 0", instret); end
    cyc(1'b0, 1'b0);
    checks++; if (obs !== O_MREQ) begin errors++; $display("FAIL addi_next_fetch: got %h expected %h", obs, O_MREQ); end
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL addi_instret_after: got %0d expected 1", instret); end
  endtask

  task automatic test_load_wait();
    logic [14:0] m;
    m = O_MREQ | O_ASEL | sel(2'd0, 2'd0, 1'b1, 2'd0);
    do_reset(); inst = 32'h0000A103;
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    checks++; if (obs !== sel(2'd0, 2'd0, 1'b1, 2'd0)) begin errors++; $display("FAIL lw_exec: got %h expected %h", obs, sel(2'd0, 2'd0, 1'b1, 2'd0)); end
    for (int i = 0; i < 4; i++) begin
      cyc(i == 3, rbit());
      checks++; if (obs !== m) begin errors++; $display("FAIL lw_mem_%0d: got %h expected %h", i, obs, m); end
    end
    cyc(1'b0, 1'b0);
    checks++; if (obs !== (O_PCWE | O_REGWE | O_RET | sel(2'd0, 2'd0, 1'b1, 2'd1))) begin
      errors++; $display("FAIL lw_wb: got %h expected %h", obs, O_PCWE | O_REGWE | O_RET | sel(2'd0, 2'd0, 1'b1, 2'd1)); end
    cyc(1'b0, 1'b0);
    checks++; if (obs !== O_MREQ) begin errors++; $display("FAIL lw_fetch_after_8: got %h expected %h", obs, O_MREQ); end
    checks++; if (instret !== 32'd1) begin errors++; $display("FAIL lw_instret: got %0d expected 1", instret); end
  endtask

  task automatic test_branch();
    int nret, nregwe;
    for (int t = 0; t < 2; t++) begin
      logic br;
      br = (t == 0);
      do_reset(); inst = 32'h00208463; nret = 0; nregwe = 0;
      cyc(1'b1, ~br); nret += int'(retire); nregwe += int'(reg_we);
      cyc(1'b0, ~br); nret += int'(retire); nregwe += int'(reg_we);
      cyc(1'b0, br);  nret += int'(retire); nregwe += int'(reg_we);
      checks++; if (obs !== (O_PCWE | O_RET | sel({1'b0, br}, 2'd0, 1'b0, 2'd0))) begin
        errors++; $display("FAIL beq_exec_br%0d: got %h expected %h", br, obs, O_PCWE | O_RET | sel({1'b0, br}, 2'd0, 1'b0, 2'd0)); end
      cyc(1'b0, ~br); nret += int'(retire); nregwe += int'(reg_we);
      checks++; if (obs !== O_MREQ) begin errors++; $display("FAIL beq_fetch_br%0d: got %h expected %h", br, obs, O_MREQ); end
      checks++; if (nret !== 1 || nregwe !== 0) begin
        errors++; $display("FAIL beq_counts_br%0d: got retire=%0d reg_we=%0d expected 1/0", br, nret, nregwe); end
      checks++; if (instret !== 32'd1) begin errors++; $display("FAIL beq_instret_br%0d: got %0d expected 1", br, instret); end
    end
  endtask

  task automatic test_jalr();
    do_reset(); inst = 32'h000280E7;
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    checks++; if (obs !== (O_PCWE | O_REGWE | O_RET | sel(2'd2, 2'd0, 1'b1, 2'd2))) begin
      errors++; $display("FAIL jalr_wb: got %h expected %h", obs, O_PCWE | O_REGWE | O_RET | sel(2'd2, 2'd0, 1'b1, 2'd2)); end
  endtask

  task automatic test_illegal();
    do_reset(); inst = 32'hFFFFFFFF;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    checks++; if (obs !== 15'h0) begin errors++; $display("FAIL ill_decode: got %h expected 0", obs); end
    for (int i = 0; i < 20; i++) begin
      cyc(rbit(), rbit());
      checks++; if (obs !== O_ILL || instret !== 32'd0) begin
        errors++; $display("FAIL ill_trap_%0d: got %h/%0d expected %h/0", i, obs, instret, O_ILL); end
    end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (obs !== 15'h0) begin errors++; $display("FAIL ill_rst_clear: got %h expected 0", obs); end
    @(negedge clk); rst = 1'b0; #1;
    cyc(1'b0, 1'b0);
    checks++; if (obs !== O_MREQ) begin errors++; $display("FAIL ill_refetch: got %h expected %h", obs, O_MREQ); end
  endtask

  task automatic test_reset_mid_mem();
    logic [14:0] m;
    m = O_MREQ | O_MWE | O_ASEL | sel(2'd0, 2'd0, 1'b1, 2'd0);
    do_reset(); inst = 32'h00500093;
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0); inst = 32'h0020A023;
    cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    checks++; if (obs !== m || instret !== 32'd1) begin
      errors++; $display("FAIL sw_mem: got %h/%0d expected %h/1", obs, instret, m); end
    #2 rst = 1'b1; #1;
    checks++; if (obs !== 15'h0 || instret !== 32'd0) begin
      errors++; $display("FAIL sw_async_rst: got %h/%0d expected 0/0", obs, instret); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (obs !== 15'h0) begin errors++; $display("FAIL sw_rst_idle: got %h expected 0", obs); end
    cyc(1'b0, 1'b0);
    checks++; if (obs !== O_MREQ) begin errors++; $display("FAIL sw_rst_fetch: got %h expected %h", obs, O_MREQ); end
  endtask

  task automatic test_random();
    logic [6:0]  opcs [11];
    logic [31:0] tmp;
    rec_t        r;
    opcs = '{OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC, SYS};
    do_reset();
    exp_instret = 32'd0;
    for (int n = 0; n < 60; n++) begin
      tmp = $urandom();
      model_inst({tmp[31:7], opcs[$urandom_range(0, 10)]}, $urandom_range(0, 3),
                 $urandom_range(0, 3), rbit());
      if (n == 0) begin
        // first cycle observed is the IDLE cycle left by reset
        checks++; if (obs !== 15'h0) begin errors++; $display("FAIL rand_idle: got %h expected 0", obs); end
      end
      while (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        @(negedge clk);
        inst = r.iw; mem_ready = r.mr; br_taken = r.br;
        #1;
        checks++; if (obs !== r.o) begin
          errors++; $display("FAIL rand_out inst=%h opc=%b: got %h expected %h", r.iw, r.iw[6:0], obs, r.o); end
        checks++; if (instret !== exp_instret) begin
          errors++; $display("FAIL rand_instret: got %0d expected %0d", instret, exp_instret); end
        if (r.o[1]) exp_instret = exp_instret + 32'd1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_wait();
    test_branch();
    test_jalr();
    test_illegal();
    test_reset_mid_mem();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32I core. It steps the shared datapath (PC, instruction register, register file, immediate generator, ALU, memory port) through fetch, decode, execute, memory and write-back. It drives every mux select and write enable in the datapath from its state and the opcode of the latched instruction. It also counts retired instructions and stops in a trap state on an unsupported opcode.

## Interface
- DATA_WIDTH, 32, instruction/data width (from shared package)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- inst  in  DATA_WIDTH  instruction register output; stable from the DECODE state onward
- mem_ready  in  1  memory accepts/completes the request in the current cycle
- br_taken  in  1  branch comparator result, valid in EXEC
- mem_req  out  1  memory request; address/data held stable until accepted
- mem_we  out  1  store request (qualifies mem_req)
- addr_sel  out  1  0 = PC, 1 = ALU result as memory address
- ir_we  out  1  load instruction register
- pc_we  out  1  update PC
- pc_sel  out  2  PC4=0, PC_IMM=1 (PC+imm), ALU=2 (JALR target; the datapath clears bit 0)
- alu_a_sel  out  2  RS1=0, PC=1, ZERO=2
- alu_b_sel  out  1  0 = RS2, 1 = immediate
- reg_we  out  1  register file write
- wb_sel  out  2  ALU=0, MEM=1, PC4=2
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  32  retired instruction count, wraps 0xFFFFFFFF -> 0
- illegal  out  1  sticky; high in TRAP

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE is the reset state. All outputs are 0. The FSM goes to FETCH unconditionally on the next cycle.
- FETCH:
  - mem_req=1, addr_sel=0, mem_we=0.
  - When mem_ready=1, ir_we=1 in that cycle and the FSM goes to DECODE. Otherwise it stays in FETCH.
- DECODE (1 cycle): opcode is classified from inst[6:0].
  - OP, OP_IMM, LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH, MISC_MEM and SYSTEM go to EXEC.
  - Any other opcode goes to TRAP.
- EXEC selects:
  - OP: RS1/RS2.
  - OP_IMM, LOAD, STORE, JALR: RS1/IMM.
  - AUIPC: PC/IMM.
  - LUI: ZERO/IMM.
  - BRANCH: RS1/RS2.
- EXEC transitions:
  - LOAD and STORE go to MEM.
  - BRANCH: pc_we=1, pc_sel=PC_IMM if br_taken else PC4, retire=1, then FETCH.
  - MISC_MEM and SYSTEM are NOPs: pc_we=1, pc_sel=PC4, retire=1, then FETCH.
  - All other classes go to WB.
- MEM:
  - mem_req=1, addr_sel=1, alu selects held at RS1/IMM, mem_we=1 for STORE.
  - Waits for mem_ready.
  - LOAD then goes to WB.
  - STORE: pc_we=1, pc_sel=PC4, retire=1 in the accept cycle, then FETCH.
- WB:
  - reg_we=1 and pc_we=1.
  - wb_sel=MEM for LOAD, PC4 for JAL/JALR, ALU otherwise.
  - pc_sel=PC_IMM for JAL, ALU for JALR, PC4 otherwise.
  - ALU selects are held as in EXEC.
  - retire=1, then FETCH.
- TRAP: all outputs 0 except illegal=1. The FSM stays in TRAP until rst.
- instret increments by 1 on every cycle with retire=1.
- mem_ready is ignored whenever mem_req=0.

## Timing
- The state register and instret are flopped. On rst assertion they clear immediately (asynchronously) to IDLE/0, from any state including mid-MEM.
- All other outputs are combinational from state, the inst opcode, br_taken and mem_ready.
- mem_req and addr_sel never glitch in the handshake cycle.
- Latency with mem_ready=1 on first request, FETCH to next FETCH:
  - OP/OP_IMM/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH/NOP: 3 cycles.
- Each cycle of mem_ready=0 in FETCH or MEM adds one cycle.
- Exactly one retire pulse per instruction, coincident with its pc_we.
- Nothing retires in DECODE, IDLE or TRAP.

## Structure
- The shared package holds:
  - DATA_WIDTH.
  - Opcode localparams: OP 0110011, OP_IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, MISC_MEM 0001111, SYSTEM 1110011. These are the same values the immediate generator decodes.
  - The state enum.
  - Encodings for pc_sel, alu_a_sel and wb_sel.
- One sub-module, inst_class_dec: combinational opcode to one-hot class plus a valid flag. It is instantiated once in this block.

## Test plan
- addi x1,x0,5 (0x00500093), mem_ready=1:
  - State sequence IDLE, FETCH, DECODE, EXEC, WB, FETCH.
  - In WB: reg_we=1, wb_sel=ALU, alu_b_sel=1, pc_sel=PC4.
  - instret goes 0 -> 1.
- lw x2,0(x1) (0x0000A103), mem_ready low 3 cycles in MEM:
  - mem_req=1 and addr_sel=1 held for 4 cycles.
  - Then WB with wb_sel=MEM.
  - Total 8 cycles FETCH to FETCH.
- beq x1,x2,+8 (0x00208463), br_taken=1 then 0 on a rerun:
  - pc_we=1 in EXEC with pc_sel=1, then pc_sel=0.
  - reg_we never asserted.
  - retire=1 once per run.
- jalr x1,0(x5) (0x000280E7):
  - In WB: wb_sel=PC4, pc_sel=ALU, alu_a_sel=RS1, alu_b_sel=1.
- Illegal 0xFFFFFFFF:
  - DECODE goes to TRAP with illegal=1.
  - No further mem_req, retire or instret change for 20 cycles.
  - rst clears illegal and returns to IDLE.
- rst asserted in MEM of a store with mem_ready=0:
  - All outputs 0 in the same cycle.
  - instret=0.
  - FETCH one cycle after rst deasserts.
